// File: rtl/player_state_tx_pkg.sv
// rtl/player_state_tx_pkg.sv - shared constants, FSM states and packet packing for the player-state link
// Purpose: one place for the packet layout so the transmitter and the peer
//          receiver agree on byte order and checksum.
// Contents:
//   HEADER_DEFAULT  sync marker placed in byte 0
//   PKT_LEN         bytes per packet
//   tx_state_t      transmitter FSM states
//   pkt_t           packed packet, byte i at bits [8*i +: 8]
//   build_pkt()     packs fields and checksum into a pkt_t
//   sat_inc8()      saturating 8-bit increment
package player_state_tx_pkg;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
  localparam int         PKT_LEN        = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } tx_state_t;

  typedef logic [PKT_LEN*8-1:0] pkt_t;

  // Byte 5 is the XOR of bytes 1..4; the header is excluded so a receiver
  // can verify without knowing which marker the sender was built with.
  function automatic pkt_t build_pkt(
    input logic [3:0]  hp,
    input logic [11:0] x,
    input logic [11:0] y,
    input logic [1:0]  game_active,
    input logic        game_start,
    input logic [7:0]  header = HEADER_DEFAULT
  );
    logic [7:0] b1, b2, b3, b4, b5;
    b1 = {1'b0, game_start, game_active, hp};
    b2 = x[11:4];
    b3 = {x[3:0], y[11:8]};
    b4 = y[7:0];
    b5 = b1 ^ b2 ^ b3 ^ b4;
    return {b5, b4, b3, b2, b1, header};
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/player_state_tx.sv
// rtl/player_state_tx.sv - frames local player state into 6-byte packets for the UART TX FIFO
// Purpose: on every SEND_DIV-th accepted frame tick, snapshot hp/position/game
//          flags and push the packet bytes one at a time into the UART FIFO.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   tx_enable       link enabled; gates the divider and new packets
//   frame_tick      one-cycle pulse per video frame
//   hp, char_x, char_y, game_active, game_start   fields sampled per packet
//   tx_full         UART TX FIFO full, stalls the byte stream
//   tx_data, tx_wr  byte and one-cycle write strobe to the UART FIFO
//   packet_sent     one-cycle pulse after the last byte of a packet
//   frames_dropped  saturating count of ticks lost while busy
module player_state_tx
  import player_state_tx_pkg::*;
#(
  parameter logic [7:0] HEADER   = HEADER_DEFAULT,
  parameter int         SEND_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_enable,
  input  logic        frame_tick,
  input  logic [3:0]  hp,
  input  logic [11:0] char_x,
  input  logic [11:0] char_y,
  input  logic [1:0]  game_active,
  input  logic        game_start,
  input  logic        tx_full,
  output logic [7:0]  tx_data,
  output logic        tx_wr,
  output logic        packet_sent,
  output logic [7:0]  frames_dropped
);

  localparam logic [7:0] DIV_LOAD = 8'(SEND_DIV - 1);

  tx_state_t  state;
  pkt_t       pkt;
  pkt_t       snap;
  logic [2:0] idx;
  logic       pending;
  logic [7:0] divider;
  logic       tick_ok;

  assign snap    = build_pkt(hp, char_x, char_y, game_active, game_start, HEADER);
  assign tick_ok = frame_tick && tx_enable && (divider == 8'd0);

  // Divider only advances on enabled ticks, so it holds while the link is off.
  always_ff @(posedge clk) begin
    if (rst) begin
      divider <= 8'd0;
    end else if (frame_tick && tx_enable) begin
      divider <= (divider == 8'd0) ? DIV_LOAD : divider - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      pkt            <= '0;
      idx            <= 3'd0;
      pending        <= 1'b0;
      tx_data        <= 8'd0;
      tx_wr          <= 1'b0;
      packet_sent    <= 1'b0;
      frames_dropped <= 8'd0;
    end else begin
      packet_sent <= 1'b0;

      // A tick while busy with one already queued is lost; this includes a
      // tick landing in DONE, where the queued one is about to be served.
      if (tick_ok && (state != ST_IDLE) && pending) begin
        frames_dropped <= sat_inc8(frames_dropped);
      end

      case (state)
        ST_IDLE: begin
          tx_wr <= 1'b0;
          if (tick_ok) begin
            pkt   <= snap;
            idx   <= 3'd0;
            state <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (tick_ok) pending <= 1'b1;
          if (!tx_full) begin
            tx_wr   <= 1'b1;
            tx_data <= pkt[{idx, 3'b000} +: 8];
            state   <= ST_GAP;
          end else begin
            tx_wr <= 1'b0;
          end
        end

        // One idle cycle after each write so tx_full reflects that write
        // before the next byte is considered.
        ST_GAP: begin
          tx_wr <= 1'b0;
          if (tick_ok) pending <= 1'b1;
          if (idx == 3'(PKT_LEN - 1)) begin
            state <= ST_DONE;
          end else begin
            idx   <= idx + 3'd1;
            state <= ST_SEND;
          end
        end

        // A queued tick is dropped here if the link went down mid-packet.
        ST_DONE: begin
          tx_wr       <= 1'b0;
          packet_sent <= 1'b1;
          pending     <= 1'b0;
          if ((pending && tx_enable) || tick_ok) begin
            pkt   <= snap;
            idx   <= 3'd0;
            state <= ST_SEND;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_player_state_tx.sv
// tb/tb_player_state_tx.sv - directed vector bench for player_state_tx
module tb_player_state_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_enable;
  logic        frame_tick;
  logic [3:0]  hp;
  logic [11:0] char_x;
  logic [11:0] char_y;
  logic [1:0]  game_active;
  logic        game_start;
  logic        tx_full;

  logic [7:0]  d1_data, d3_data;
  logic        d1_wr, d3_wr;
  logic        d1_sent, d3_sent;
  logic [7:0]  d1_drop, d3_drop;

  always #5 clk = ~clk;

  player_state_tx #(.HEADER(8'hA5), .SEND_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .tx_enable(tx_enable), .frame_tick(frame_tick),
    .hp(hp), .char_x(char_x), .char_y(char_y), .game_active(game_active),
    .game_start(game_start), .tx_full(tx_full),
    .tx_data(d1_data), .tx_wr(d1_wr), .packet_sent(d1_sent), .frames_dropped(d1_drop)
  );

  player_state_tx #(.HEADER(8'hA5), .SEND_DIV(3)) u_dut3 (
    .clk(clk), .rst(rst), .tx_enable(tx_enable), .frame_tick(frame_tick),
    .hp(hp), .char_x(char_x), .char_y(char_y), .game_active(game_active),
    .game_start(game_start), .tx_full(tx_full),
    .tx_data(d3_data), .tx_wr(d3_wr), .packet_sent(d3_sent), .frames_dropped(d3_drop)
  );

  typedef struct {
    logic [3:0]  hp;
    logic [11:0] x;
    logic [11:0] y;
    logic [1:0]  ga;
    logic        gs;
    logic [47:0] exp;   // byte 0 in bits [47:40]
  } vec_t;

  vec_t vecs [4];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int tick_cyc;
  int sent_cnt;
  int sent_cyc;
  int wr3_cnt = 0;
  int b2b     = 0;
  logic prev_wr = 1'b0;
  logic [7:0] wr_q [$];
  int         wr_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (d1_wr) begin
      wr_q.push_back(d1_data);
      wr_cyc.push_back(cyc);
      if (prev_wr) b2b++;
    end
    prev_wr = d1_wr;
    if (d1_sent) begin
      sent_cnt++;
      sent_cyc = cyc;
    end
    if (d3_wr) wr3_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    tick_cyc   = cyc;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic clear_mon();
    wr_q.delete();
    wr_cyc.delete();
    sent_cnt = 0;
  endtask

  task automatic set_vec(input vec_t v);
    hp = v.hp; char_x = v.x; char_y = v.y; game_active = v.ga; game_start = v.gs;
  endtask

  task automatic reset_dut();
    frame_tick = 1'b0;
    tx_full    = 1'b0;
    tx_enable  = 1'b1;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step();
  endtask

  task automatic wait_wr(input int n, input int budget, input string name);
    int k = 0;
    while (wr_q.size() < n && k < budget) begin
      step();
      k++;
    end
    n_tests++;
    if (wr_q.size() < n) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d writes expected %0d", name, wr_q.size(), n);
    end
  endtask

  task automatic check_bytes(input string name, input int base, input logic [47:0] exp);
    for (int i = 0; i < 6; i++) begin
      if (base + i < wr_q.size())
        check($sformatf("%s_b%0d", name, i), 32'(wr_q[base + i]), 32'(exp[8*(5-i) +: 8]));
      else
        check($sformatf("%s_b%0d_missing", name, i), 32'(0), 32'(1));
    end
  endtask

  initial begin
    int before1, before3, stall_bad;

    vecs[0] = '{hp: 4'd7,  x: 12'h123, y: 12'h2AB, ga: 2'd1, gs: 1'b0, exp: 48'hA5_17_12_32_AB_9C};
    vecs[1] = '{hp: 4'hF,  x: 12'hFFF, y: 12'h000, ga: 2'd3, gs: 1'b1, exp: 48'hA5_7F_FF_F0_00_70};
    vecs[2] = '{hp: 4'h0,  x: 12'h000, y: 12'h000, ga: 2'd0, gs: 1'b0, exp: 48'hA5_00_00_00_00_00};
    vecs[3] = '{hp: 4'hC,  x: 12'hABC, y: 12'h5DE, ga: 2'd2, gs: 1'b0, exp: 48'hA5_2C_AB_C5_DE_9C};

    rst = 1'b1; tx_enable = 1'b1; frame_tick = 1'b0; tx_full = 1'b0;
    set_vec(vecs[0]);
    step(3);
    check("rst_tx_wr",   32'(d1_wr),   32'(0));
    check("rst_tx_data", 32'(d1_data), 32'(0));
    check("rst_sent",    32'(d1_sent), 32'(0));
    check("rst_dropped", 32'(d1_drop), 32'(0));
    rst = 1'b0;
    step();

    // Table: one packet per vector, SEND_DIV=1, no backpressure.
    for (int v = 0; v < 4; v++) begin
      clear_mon();
      set_vec(vecs[v]);
      tick();
      wait_wr(6, 40, $sformatf("vec%0d", v));
      step(8);
      check_bytes($sformatf("vec%0d", v), 0, vecs[v].exp);
      check($sformatf("vec%0d_nwr", v),  32'(wr_q.size()), 32'(6));
      check($sformatf("vec%0d_sent", v), 32'(sent_cnt),    32'(1));
      if (v == 0 && wr_cyc.size() == 6) begin
        check("lat_first_wr", 32'(wr_cyc[0] - tick_cyc), 32'(2));
        check("lat_last_wr",  32'(wr_cyc[5] - tick_cyc), 32'(12));
        check("lat_sent",     32'(sent_cyc - tick_cyc),  32'(14));
      end
    end

    // Backpressure after the 2nd byte for 20 cycles.
    reset_dut();
    clear_mon();
    set_vec(vecs[0]);
    tick();
    wait_wr(2, 20, "bp_pre");
    tx_full = 1'b1;
    stall_bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (d1_wr !== 1'b0 || d1_data !== 8'h17) stall_bad++;
    end
    tx_full = 1'b0;
    check("bp_stall", 32'(stall_bad), 32'(0));
    wait_wr(6, 40, "bp_post");
    step(8);
    check_bytes("bp", 0, vecs[0].exp);
    check("bp_nwr",  32'(wr_q.size()), 32'(6));
    check("bp_sent", 32'(sent_cnt),    32'(1));

    // Busy ticks: three ticks mid-packet -> one follow-up with DONE-time inputs.
    reset_dut();
    clear_mon();
    set_vec(vecs[0]);
    tick();
    wait_wr(1, 20, "busy_pre");
    tx_full = 1'b1;
    tick(); tick(); tick();
    set_vec(vecs[1]);
    step(2);
    tx_full = 1'b0;
    wait_wr(12, 80, "busy_post");
    step(8);
    check_bytes("busy_p0", 0, vecs[0].exp);
    check_bytes("busy_p1", 6, vecs[1].exp);
    check("busy_nwr",     32'(wr_q.size()), 32'(12));
    check("busy_sent",    32'(sent_cnt),    32'(2));
    check("busy_dropped", 32'(d1_drop),     32'(2));

    // Divider: SEND_DIV=3 instance sends on ticks 1, 4, 7 of 9.
    reset_dut();
    set_vec(vecs[0]);
    for (int k = 0; k < 9; k++) begin
      before3 = wr3_cnt;
      tick();
      step(20);
      check($sformatf("div_tick%0d", k + 1), 32'(wr3_cnt - before3), (k % 3 == 0) ? 32'(6) : 32'(0));
    end
    tx_enable = 1'b0;
    before1 = wr_q.size();
    before3 = wr3_cnt;
    for (int k = 0; k < 9; k++) begin
      tick();
      step(4);
    end
    step(20);
    check("dis_wr1", 32'(wr_q.size() - before1), 32'(0));
    check("dis_wr3", 32'(wr3_cnt - before3),     32'(0));
    tx_enable = 1'b1;

    // Reset after the 3rd byte, then a clean packet.
    reset_dut();
    clear_mon();
    set_vec(vecs[3]);
    tick();
    wait_wr(3, 20, "rmid_pre");
    rst = 1'b1;
    step();
    check("rmid_tx_wr",   32'(d1_wr),   32'(0));
    check("rmid_tx_data", 32'(d1_data), 32'(0));
    check("rmid_sent",    32'(d1_sent), 32'(0));
    check("rmid_dropped", 32'(d1_drop), 32'(0));
    step();
    rst = 1'b0;
    step(4);
    clear_mon();
    set_vec(vecs[0]);
    tick();
    wait_wr(6, 40, "rmid_post");
    step(8);
    check_bytes("rmid", 0, vecs[0].exp);
    check("rmid_nwr", 32'(wr_q.size()), 32'(6));

    // Saturation: packet stalled, 300 ticks total.
    reset_dut();
    tx_full = 1'b1;
    tick();
    frame_tick = 1'b1;
    step(100);
    frame_tick = 1'b0;
    step();
    check("sat_99", 32'(d1_drop), 32'(99));
    frame_tick = 1'b1;
    step(199);
    frame_tick = 1'b0;
    step();
    check("sat_255", 32'(d1_drop), 32'(255));
    tx_full = 1'b0;
    step(40);

    check("no_back_to_back_wr", 32'(b2b), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
